// File: rtl/lcd_char_driver_pkg.sv
// Shared types and constants for the HD44780 4-bit character driver:
// FSM encodings, LCD command bytes, delays in microseconds and the init ROM.
package lcd_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT,
    IDLE,
    FETCH,
    PRE_CMD,
    SEND_HI,
    SEND_LO,
    EXEC_WAIT
  } lcd_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SETUP,
    TX_HIGH,
    TX_HOLD
  } tx_phase_e;

  localparam logic [7:0] CMD_FUNC_4BIT = 8'h28;
  localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_ENTRY     = 8'h06;
  localparam logic [7:0] CMD_LINE0     = 8'h80;
  localparam logic [7:0] CMD_LINE1     = 8'hC0;

  localparam int unsigned PWR_WAIT_US   = 20000;
  localparam int unsigned INIT_WAIT0_US = 5000;
  localparam int unsigned INIT_WAIT_US  = 100;
  localparam int unsigned CLEAR_WAIT_US = 2000;
  localparam int unsigned CMD_WAIT_US   = 50;

  localparam logic [7:0] CHAR_NEWLINE = 8'h0A;
  localparam logic [7:0] CHAR_CLEAR   = 8'h0C;
  localparam logic [7:0] CHAR_FIRST   = 8'h20;
  localparam logic [7:0] CHAR_LAST    = 8'h7E;

  localparam logic [4:0] LINE_COLS  = 5'd16;
  localparam logic [3:0] INIT_STEPS = 4'd8;

  typedef struct packed {
    logic [7:0]  code;
    logic        full;     // 1: full byte (two nibbles), 0: low nibble only
    logic [15:0] wait_us;
  } init_step_t;

  function automatic init_step_t init_rom(input logic [2:0] idx);
    init_step_t s;
    s = '{code: 8'h03, full: 1'b0, wait_us: 16'(INIT_WAIT_US)};
    case (idx)
      3'd0: s.wait_us = 16'(INIT_WAIT0_US);
      3'd3: s.code = 8'h02;
      3'd4: s = '{code: CMD_FUNC_4BIT, full: 1'b1, wait_us: 16'(CMD_WAIT_US)};
      3'd5: s = '{code: CMD_DISP_ON,   full: 1'b1, wait_us: 16'(CMD_WAIT_US)};
      3'd6: s = '{code: CMD_CLEAR,     full: 1'b1, wait_us: 16'(CLEAR_WAIT_US)};
      3'd7: s = '{code: CMD_ENTRY,     full: 1'b1, wait_us: 16'(CMD_WAIT_US)};
      default: ;
    endcase
    return s;
  endfunction

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= CHAR_FIRST) && (b <= CHAR_LAST);
  endfunction

  // Set-address command that moves the cursor to the start of the other line.
  function automatic logic [7:0] other_line_cmd(input logic line);
    return line ? CMD_LINE0 : CMD_LINE1;
  endfunction

endpackage

// File: rtl/lcd_char_driver_nibble_tx.sv
// Transfers one nibble to the LCD: RS/D setup, E high, E low hold, each
// US_CYC cycles long; done_o pulses in the last hold cycle.
module lcd_nibble_tx
  import lcd_pkg::*;
#(
  parameter int unsigned US_CYC = 1
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [3:0] nib_i,
  input  logic       rs_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       lcd_e_o,
  output logic       lcd_rs_o,
  output logic [3:0] lcd_d_o
);

  localparam int unsigned CNT_W = (US_CYC > 1) ? $clog2(US_CYC) : 1;
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_LAST = cnt_t'(US_CYC - 1);

  tx_phase_e  phase_q, phase_d;
  cnt_t       cnt_q, cnt_d;
  logic [3:0] d_q, d_d;
  logic       rs_q, rs_d;
  logic       e_q, e_d;
  logic       last;

  assign last = (cnt_q == CNT_LAST);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      phase_q <= TX_IDLE;
      cnt_q   <= '0;
      d_q     <= '0;
      rs_q    <= 1'b0;
      e_q     <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      rs_q    <= rs_d;
      e_q     <= e_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    rs_d    = rs_q;
    case (phase_q)
      TX_IDLE: begin
        if (start_i) begin
          phase_d = TX_SETUP;
          cnt_d   = '0;
          d_d     = nib_i;
          rs_d    = rs_i;
        end
      end
      default: begin
        if (last) begin
          cnt_d = '0;
          case (phase_q)
            TX_SETUP: phase_d = TX_HIGH;
            TX_HIGH:  phase_d = TX_HOLD;
            default:  phase_d = TX_IDLE;
          endcase
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
    endcase
    // E is registered so the pin never glitches between phases.
    e_d = (phase_d == TX_HIGH);
  end

  always_comb begin
    busy_o = (phase_q != TX_IDLE);
    done_o = (phase_q == TX_HOLD) && last;
  end

  assign lcd_e_o  = e_q;
  assign lcd_rs_o = rs_q;
  assign lcd_d_o  = d_q;

endmodule

// File: rtl/lcd_char_driver.sv
// Pops bytes from the display FIFO and drives a 16x2 HD44780 LCD in 4-bit
// write-only mode, including power-on init, newline/clear and line wrap.
module lcd_char_driver
  import lcd_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [7:0] fifo_data_i,
  input  logic       fifo_empty_i,
  output logic       fifo_rden_o,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic       lcd_e_o,
  output logic [3:0] lcd_d_o,
  output logic       busy_o
);

  localparam int unsigned US_CYC = CLK_HZ / 1_000_000;
  localparam int unsigned WAIT_W = $clog2(PWR_WAIT_US * US_CYC + 1);
  typedef logic [WAIT_W-1:0] wait_t;

  function automatic wait_t us_to_cyc(input int unsigned us);
    return wait_t'(us * US_CYC - 1);
  endfunction

  lcd_state_e state_q, state_d;
  wait_t      wait_q, wait_d;
  wait_t      exec_q, exec_d;
  logic [7:0] byte_q, byte_d;
  logic [7:0] out_byte_q, out_byte_d;
  logic       out_rs_q, out_rs_d;
  logic       pending_q, pending_d;
  logic       line_q, line_d;
  logic [4:0] col_q, col_d;
  logic [3:0] init_step_q, init_step_d;
  logic       init_done_q, init_done_d;

  init_step_t init_step;
  logic       tx_start, tx_busy, tx_done;
  logic [3:0] tx_nib;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= PWR_WAIT;
      wait_q      <= us_to_cyc(PWR_WAIT_US);
      exec_q      <= '0;
      byte_q      <= '0;
      out_byte_q  <= '0;
      out_rs_q    <= 1'b0;
      pending_q   <= 1'b0;
      line_q      <= 1'b0;
      col_q       <= '0;
      init_step_q <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      exec_q      <= exec_d;
      byte_q      <= byte_d;
      out_byte_q  <= out_byte_d;
      out_rs_q    <= out_rs_d;
      pending_q   <= pending_d;
      line_q      <= line_d;
      col_q       <= col_d;
      init_step_q <= init_step_d;
      init_done_q <= init_done_d;
    end
  end

  // Init nibbles and wrapped writes reuse SEND_HI/SEND_LO/EXEC_WAIT;
  // EXEC_WAIT decides whether to resume init, finish a wrap, or idle.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    exec_d      = exec_q;
    byte_d      = byte_q;
    out_byte_d  = out_byte_q;
    out_rs_d    = out_rs_q;
    pending_d   = pending_q;
    line_d      = line_q;
    col_d       = col_q;
    init_step_d = init_step_q;
    init_done_d = init_done_q;
    init_step   = init_rom(init_step_q[2:0]);
    case (state_q)
      PWR_WAIT: begin
        if (wait_q == '0) state_d = INIT;
        else              wait_d  = wait_q - wait_t'(1);
      end
      INIT: begin
        if (init_step_q == INIT_STEPS) begin
          init_done_d = 1'b1;
          state_d     = IDLE;
        end else begin
          out_byte_d  = init_step.code;
          out_rs_d    = 1'b0;
          exec_d      = us_to_cyc(32'(init_step.wait_us));
          init_step_d = init_step_q + 4'd1;
          state_d     = init_step.full ? SEND_HI : SEND_LO;
        end
      end
      IDLE: begin
        if (!fifo_empty_i) begin
          byte_d  = fifo_data_i;
          state_d = FETCH;
        end
      end
      FETCH: begin
        state_d  = IDLE;
        out_rs_d = 1'b0;
        exec_d   = us_to_cyc(CMD_WAIT_US);
        if (byte_q == CHAR_NEWLINE) begin
          out_byte_d = other_line_cmd(line_q);
          line_d     = ~line_q;
          col_d      = '0;
          state_d    = SEND_HI;
        end else if (byte_q == CHAR_CLEAR) begin
          out_byte_d = CMD_CLEAR;
          line_d     = 1'b0;
          col_d      = '0;
          exec_d     = us_to_cyc(CLEAR_WAIT_US);
          state_d    = SEND_HI;
        end else if (is_printable(byte_q)) begin
          if (col_q == LINE_COLS) begin
            out_byte_d = other_line_cmd(line_q);
            line_d     = ~line_q;
            col_d      = 5'd1;
            pending_d  = 1'b1;
            state_d    = PRE_CMD;
          end else begin
            out_byte_d = byte_q;
            out_rs_d   = 1'b1;
            col_d      = col_q + 5'd1;
            state_d    = SEND_HI;
          end
        end
      end
      PRE_CMD: state_d = SEND_HI;
      SEND_HI: begin
        if (tx_done) state_d = SEND_LO;
      end
      SEND_LO: begin
        if (tx_done) begin
          wait_d  = exec_q;
          state_d = EXEC_WAIT;
        end
      end
      EXEC_WAIT: begin
        if (wait_q != '0) begin
          wait_d = wait_q - wait_t'(1);
        end else if (!init_done_q) begin
          state_d = INIT;
        end else if (pending_q) begin
          out_byte_d = byte_q;
          out_rs_d   = 1'b1;
          exec_d     = us_to_cyc(CMD_WAIT_US);
          pending_d  = 1'b0;
          state_d    = SEND_HI;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = PWR_WAIT;
    endcase
  end

  always_comb begin
    fifo_rden_o = (state_q == FETCH);
    busy_o      = (state_q != IDLE);
    tx_start    = ((state_q == SEND_HI) || (state_q == SEND_LO)) && !tx_busy;
    tx_nib      = (state_q == SEND_HI) ? out_byte_q[7:4] : out_byte_q[3:0];
  end

  assign lcd_rw_o = 1'b0;

  lcd_nibble_tx #(.US_CYC(US_CYC)) u_tx (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .start_i  (tx_start),
    .nib_i    (tx_nib),
    .rs_i     (out_rs_q),
    .busy_o   (tx_busy),
    .done_o   (tx_done),
    .lcd_e_o  (lcd_e_o),
    .lcd_rs_o (lcd_rs_o),
    .lcd_d_o  (lcd_d_o)
  );

endmodule

// File: tb/tb_lcd_char_driver.sv
// Directed bench for lcd_char_driver at CLK_HZ = 1 MHz (one cycle per us):
// logs E pulses and pops at the falling clock edge and checks them.
module tb_lcd_char_driver;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_empty = 1'b1;
  logic       fifo_rden, lcd_rs, lcd_rw, lcd_e, busy;
  logic [3:0] lcd_d;

  always #5 clk = ~clk;

  lcd_char_driver #(.CLK_HZ(1_000_000)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .fifo_data_i  (fifo_data),
    .fifo_empty_i (fifo_empty),
    .fifo_rden_o  (fifo_rden),
    .lcd_rs_o     (lcd_rs),
    .lcd_rw_o     (lcd_rw),
    .lcd_e_o      (lcd_e),
    .lcd_d_o      (lcd_d),
    .busy_o       (busy)
  );

  localparam logic [4:0] INIT_EXP [12] = '{5'h03, 5'h03, 5'h03, 5'h02, 5'h02, 5'h08,
                                           5'h00, 5'h0C, 5'h00, 5'h01, 5'h00, 5'h06};

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int e_run = 0, r_run = 0, busy_fall = -1;
  logic e_prev = 1'b0, rd_prev = 1'b0, busy_prev = 1'b1;
  logic [4:0] pins_prev = '0;

  logic [7:0] fifo_mem[$];
  logic [4:0] ev_nib[$];
  int ev_cyc[$], fall_cyc[$], ehigh_w[$], pop_cyc[$], rden_w[$];
  logic setup_ok[$], hold_ok[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -100000;
  endfunction

  task automatic update_fifo_pins();
    fifo_empty = (fifo_mem.size() == 0);
    fifo_data  = fifo_empty ? 8'h00 : fifo_mem[0];
  endtask

  task automatic push(input logic [7:0] b);
    fifo_mem.push_back(b);
    update_fifo_pins();
  endtask

  task automatic clear_log();
    ev_nib.delete(); ev_cyc.delete(); fall_cyc.delete(); ehigh_w.delete();
    pop_cyc.delete(); rden_w.delete(); setup_ok.delete(); hold_ok.delete();
    e_prev = 1'b0; rd_prev = 1'b0; e_run = 0; r_run = 0; busy_fall = -1; busy_prev = 1'b1;
  endtask

  task automatic step();
    logic [4:0] pins;
    @(negedge clk);
    cyc++;
    pins = {lcd_rs, lcd_d};
    if (lcd_e && !e_prev) begin
      ev_nib.push_back(pins);
      ev_cyc.push_back(cyc);
      setup_ok.push_back(pins == pins_prev);
    end
    if (lcd_e) begin
      e_run++;
    end else if (e_prev) begin
      ehigh_w.push_back(e_run);
      fall_cyc.push_back(cyc);
      hold_ok.push_back(ev_nib.size() > 0 && pins == ev_nib[ev_nib.size()-1]);
      e_run = 0;
    end
    e_prev = lcd_e;
    pins_prev = pins;
    if (fifo_rden) begin
      if (!rd_prev) pop_cyc.push_back(cyc);
      r_run++;
      if (fifo_mem.size() > 0) void'(fifo_mem.pop_front());
    end else if (rd_prev) begin
      rden_w.push_back(r_run);
      r_run = 0;
    end
    rd_prev = fifo_rden;
    if (!busy && busy_prev) busy_fall = cyc;
    busy_prev = busy;
    update_fifo_pins();
  endtask

  task automatic run_idle(input int limit, input string tag);
    int quiet = 0;
    int n = 0;
    while (quiet < 5 && n < limit) begin
      step();
      n++;
      if (!busy && fifo_empty && !lcd_e) quiet++;
      else quiet = 0;
    end
    check({tag, "_done"}, 32'(quiet >= 5), 32'd1);
  endtask

  task automatic expect_nibs(input string tag, input logic [4:0] exp[$]);
    check({tag, "_count"}, 32'(ev_nib.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      check(tag, (i < ev_nib.size()) ? 32'(ev_nib[i]) : 32'hDEAD, 32'(exp[i]));
  endtask

  task automatic check_init_run(input string tag);
    logic [4:0] exp[$];
    for (int i = 0; i < 12; i++) exp.push_back(INIT_EXP[i]);
    expect_nibs({tag, "_nib"}, exp);
    check({tag, "_pwr_wait"}, 32'(qget(ev_cyc, 0) >= 20001), 32'd1);
    check({tag, "_wait5000"}, 32'(qget(ev_cyc, 1) - qget(ev_cyc, 0) >= 5000), 32'd1);
    check({tag, "_wait_clear"}, 32'(qget(ev_cyc, 10) - qget(ev_cyc, 9) >= 2000), 32'd1);
    check({tag, "_busy_fall"}, 32'(busy_fall - qget(fall_cyc, 11) >= 50), 32'd1);
  endtask

  initial begin
    logic [4:0] exp[$];
    logic       all_ok;
    int         n;

    // Reset state
    update_fifo_pins();
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_rden", 32'(fifo_rden), 32'd0);
    check("rst_rs",   32'(lcd_rs),    32'd0);
    check("rst_rw",   32'(lcd_rw),    32'd0);
    check("rst_e",    32'(lcd_e),     32'd0);
    check("rst_d",    32'(lcd_d),     32'd0);
    check("rst_busy", 32'(busy),      32'd1);
    reset = 1'b0;
    cyc = 0;
    clear_log();

    // Power-on initialisation
    run_idle(40000, "init");
    check_init_run("init");
    check("init_pops", 32'(pop_cyc.size()), 32'd0);

    // Printable byte followed by two newlines
    clear_log();
    push(8'h41); push(8'h0A); push(8'h0A);
    run_idle(2000, "byte");
    exp = '{5'h14, 5'h11, 5'h0C, 5'h00, 5'h08, 5'h00};
    expect_nibs("byte_nib", exp);
    check("byte_pops", 32'(pop_cyc.size()), 32'd3);
    all_ok = (rden_w.size() == 3);
    foreach (rden_w[i]) all_ok &= (rden_w[i] == 1);
    check("rden_width", 32'(all_ok), 32'd1);
    all_ok = (ehigh_w.size() == 6);
    foreach (ehigh_w[i]) all_ok &= (ehigh_w[i] == 1);
    check("e_width", 32'(all_ok), 32'd1);
    all_ok = (setup_ok.size() == 6) && (hold_ok.size() == 6);
    foreach (setup_ok[i]) all_ok &= setup_ok[i];
    foreach (hold_ok[i]) all_ok &= hold_ok[i];
    check("setup_hold", 32'(all_ok), 32'd1);
    check("pop_spacing", 32'(qget(pop_cyc, 1) - qget(fall_cyc, 1) >= 50), 32'd1);

    // Line wrap after 16 characters
    clear_log();
    for (int i = 0; i < 17; i++) push(8'h30);
    run_idle(3000, "wrap");
    exp.delete();
    for (int i = 0; i < 16; i++) begin exp.push_back(5'h13); exp.push_back(5'h10); end
    exp.push_back(5'h0C); exp.push_back(5'h00);
    exp.push_back(5'h13); exp.push_back(5'h10);
    expect_nibs("wrap_nib", exp);
    check("wrap_pops", 32'(pop_cyc.size()), 32'd17);

    // Clear, discarded control byte, then a character
    clear_log();
    push(8'h0C); push(8'h07); push(8'h41);
    run_idle(4000, "clear");
    exp = '{5'h00, 5'h01, 5'h14, 5'h11};
    expect_nibs("clear_nib", exp);
    check("clear_pops", 32'(pop_cyc.size()), 32'd3);
    check("clear_wait", 32'(qget(pop_cyc, 1) - qget(fall_cyc, 1) >= 2000), 32'd1);
    check("discard_gap", 32'(qget(pop_cyc, 2) - qget(pop_cyc, 1)), 32'd2);
    check("discard_no_e", 32'(qget(ev_cyc, 2) > qget(pop_cyc, 2)), 32'd1);

    // Asynchronous reset while E is high
    clear_log();
    push(8'h41);
    n = 0;
    while (!lcd_e && n < 500) begin step(); n++; end
    check("e_high_seen", 32'(lcd_e), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_e",    32'(lcd_e),     32'd0);
    check("async_busy", 32'(busy),      32'd1);
    check("async_d",    32'(lcd_d),     32'd0);
    check("async_rs",   32'(lcd_rs),    32'd0);
    check("async_rden", 32'(fifo_rden), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    clear_log();
    run_idle(40000, "reinit");
    check_init_run("reinit");
    check("reinit_pops", 32'(pop_cyc.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_char_driver.md
# lcd_char_driver

Downstream consumer of the display byte FIFO: pops one character at a time and drives an HD44780-compatible 16x2 character LCD in 4-bit write-only mode. Performs the power-on initialisation sequence, maps control bytes (newline, clear) to LCD commands, and handles line wrap. Sits between the display FIFO read port and the board LCD pins.

## Interface
- CLK_HZ, 100_000_000, clock frequency; derives US_CYC = CLK_HZ/1_000_000 cycles per µs (must be ≥ 1)
- clk_i  in  1  system clock
- reset_i  in  1  reset, asynchronous, active-high
- fifo_data_i  in  8  FIFO head byte (show-ahead, valid whenever FIFO not empty)
- fifo_empty_i  in  1  FIFO empty flag
- fifo_rden_o  out  1  one-cycle pop strobe
- lcd_rs_o  out  1  register select (0 command, 1 data)
- lcd_rw_o  out  1  tied 0 (write-only)
- lcd_e_o  out  1  enable strobe
- lcd_d_o  out  4  data nibble (LCD D7..D4)
- busy_o  out  1  high during init or while a byte is in progress

## Operation
- Reset values: fifo_rden_o 0, lcd_rs_o 0, lcd_rw_o 0, lcd_e_o 0, lcd_d_o 0, busy_o 1, line 0, column 0, state PWR_WAIT.
- States: PWR_WAIT → INIT → IDLE → FETCH → [PRE_CMD] → SEND_HI → SEND_LO → EXEC_WAIT → IDLE.
- PWR_WAIT: 20000 µs.
- INIT: nibble 0x3, wait 5000 µs; 0x3, wait 100 µs; 0x3, wait 100 µs; 0x2, wait 100 µs; then full commands 0x28, 0x0C, 0x01 (wait 2000 µs), 0x06, each other command followed by 50 µs. All RS=0. Then IDLE, busy_o=0.
- IDLE: if !fifo_empty_i, latch fifo_data_i, assert fifo_rden_o for exactly one cycle, busy_o=1, go FETCH. Never pop while busy.
- FETCH decode:
  - 0x0A: command 0xC0 if line 0 else 0x80; toggle line; column 0.
  - 0x0C: command 0x01; line 0, column 0; exec wait 2000 µs.
  - 0x20–0x7E: data write RS=1. If column = 16, first issue PRE_CMD set-address (0xC0 if line 0 else 0x80), toggle line, column 0. After write, column +1.
  - Any other byte: discarded, no LCD traffic, return to IDLE next cycle.
- Nibble transfer (SEND_HI then SEND_LO, high nibble first): RS and D stable 1 µs setup, E high 1 µs, E low 1 µs hold with RS/D unchanged.
- EXEC_WAIT: 50 µs after low nibble (2000 µs for 0x01), then IDLE.
- Column counter 5 bits, range 0..16; line 1 bit.

## Timing
- Pop latency: fifo_rden_o asserted the cycle after IDLE samples !fifo_empty_i; byte captured on that same edge.
- All delays measured in whole µs via US_CYC-cycle prescaler; wait counter sized $clog2(20000*US_CYC+1).
- Minimum spacing between pops: printable byte ≥ 6 µs + 50 µs; wrapped byte adds one command transfer.
- reset_i mid-operation: all outputs return to reset values asynchronously (lcd_e_o falls immediately); init restarts from PWR_WAIT; latched byte lost.

## Structure
- Package lcd_pkg: state enum, command constants (CMD_FUNC_4BIT=0x28, CMD_DISP_ON=0x0C, CMD_CLEAR=0x01, CMD_ENTRY=0x06, CMD_LINE0=0x80, CMD_LINE1=0xC0), delay constants in µs, char codes 0x0A/0x0C.
- Sub-module lcd_nibble_tx: start/done handshake, drives E/D/RS timing for one nibble; top FSM sequences it.

## Test plan
(CLK_HZ=1_000_000 for all; US_CYC=1.)
- Reset release → first lcd_e_o rise ≥ 20001 cycles later with D=0x3; nibble sequence 3,3,3,2,2,8,0,C,0,1,0,6 with RS=0; busy_o falls after final 50 µs.
- FIFO holds 0x41 → one-cycle fifo_rden_o, nibbles 0x4 then 0x1 with RS=1, E high 1 cycle each; next pop ≥ 50 cycles after last E fall.
- Bytes 0x0A, 0x0A → commands 0xC0 then 0x80, RS=0.
- 17 bytes 0x30 → 16 data writes, then command 0xC0, then 17th data write.
- Bytes 0x0C, 0x07, 0x41 → command 0x01, 2000-cycle wait, 0x07 popped with no E pulse, then 0x41 written.
- reset_i asserted while lcd_e_o high → lcd_e_o 0 with no clock edge; init sequence replays from PWR_WAIT.
